// File: rtl/fft_stage_addr_gen.sv
// Radix-2 DIF butterfly address sequencer for one in-place FFT stage.
// Emits A/B read addresses plus twiddle index; write-back replays reads LAT cycles later.
module fft_stage_addr_gen #(
    parameter int LOG2N = 8,
    parameter int LAT   = 4,
    parameter int STW   = $clog2(LOG2N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [STW-1:0]   stage,
    input  logic             hold,
    output logic             busy,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr,
    output logic             rd_sel,
    output logic             tw_en,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr,
    output logic             wr_sel,
    output logic             done,
    output logic             err
);
    // state | meaning
    // IDLE  | waiting for start; first A read is issued on the accepting edge
    // RD_A  | next edge issues the A read of butterfly b
    // RD_B  | next edge issues the B read of butterfly b
    // DRAIN | reads finished, waiting for the last write to leave the delay line
    // DONE  | done pulse cycle
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, DRAIN, DONE} state_t;

    localparam int HB = LOG2N - 1;
    localparam int CW = $clog2(LAT + 1);

    state_t           state_q;
    logic [HB-1:0]    b_q;
    logic [STW-1:0]   stage_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, err_q;
    logic             rd_en_q, rd_sel_q, tw_en_q;
    logic [LOG2N-1:0] rd_addr_q;
    logic [HB-1:0]    tw_addr_q;
    logic [LAT-1:0]   en_dl_q, sel_dl_q;
    logic [LOG2N-1:0] addr_dl_q [LAT];

    logic [STW-1:0]   sh_d;
    logic [LOG2N-1:0] h_d, j_d, g_d, addr_a_d, addr_b_d;
    logic [HB-1:0]    tw_d;

    // h = 2^(LOG2N-1-s); butterfly b splits into group g and offset j within the group
    always_comb begin
        sh_d     = STW'(HB) - stage_q;
        h_d      = LOG2N'(1) << sh_d;
        j_d      = {1'b0, b_q} & (h_d - 1'b1);
        g_d      = {1'b0, b_q} >> sh_d;
        addr_a_d = ((g_d << sh_d) << 1) | j_d;
        addr_b_d = addr_a_d + h_d;
        tw_d     = HB'(j_d << stage_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            b_q       <= '0;
            stage_q   <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_sel_q  <= 1'b0;
            tw_en_q   <= 1'b0;
            rd_addr_q <= '0;
            tw_addr_q <= '0;
            en_dl_q   <= '0;
            sel_dl_q  <= '0;
            for (int i = 0; i < LAT; i++) addr_dl_q[i] <= '0;
        end else begin
            en_dl_q[0]   <= rd_en_q;
            sel_dl_q[0]  <= rd_sel_q;
            addr_dl_q[0] <= rd_addr_q;
            for (int i = 1; i < LAT; i++) begin
                en_dl_q[i]   <= en_dl_q[i-1];
                sel_dl_q[i]  <= sel_dl_q[i-1];
                addr_dl_q[i] <= addr_dl_q[i-1];
            end
            rd_en_q <= 1'b0;
            tw_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (int'(stage) < LOG2N) begin
                            stage_q   <= stage;
                            b_q       <= '0;
                            busy_q    <= 1'b1;
                            rd_en_q   <= 1'b1;
                            rd_sel_q  <= 1'b0;
                            rd_addr_q <= '0;
                            tw_en_q   <= 1'b1;
                            tw_addr_q <= '0;
                            state_q   <= RD_B;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RD_A: begin
                    if (!hold) begin
                        rd_en_q   <= 1'b1;
                        rd_sel_q  <= 1'b0;
                        rd_addr_q <= addr_a_d;
                        tw_en_q   <= 1'b1;
                        tw_addr_q <= tw_d;
                        state_q   <= RD_B;
                    end
                end
                RD_B: begin
                    if (!hold) begin
                        rd_en_q   <= 1'b1;
                        rd_sel_q  <= 1'b1;
                        rd_addr_q <= addr_b_d;
                        if (b_q == '1) begin
                            cnt_q   <= CW'(LAT);
                            state_q <= DRAIN;
                        end else begin
                            b_q     <= b_q + 1'b1;
                            state_q <= RD_A;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rd_en   = rd_en_q;
    assign rd_sel  = rd_sel_q;
    assign rd_addr = rd_addr_q;
    assign tw_en   = tw_en_q;
    assign tw_addr = tw_addr_q;
    assign wr_en   = en_dl_q[LAT-1];
    assign wr_sel  = sel_dl_q[LAT-1];
    assign wr_addr = addr_dl_q[LAT-1];

endmodule
